hbridge_driver: RTL

- Consumes the 4-bit motor direction command and 2-bit enable produced by the line-following motor controller.
- Drives a dual H-bridge (L298-style IN1..IN4, ENA/ENB) with PWM speed control.
- Inserts dead-time on every direction reversal so that neither bridge leg shoot-throughs or hard-reverses.
- Sits between the motor controller and the board pins; it is the only block allowed to touch the bridge pins.

---
 rtl/hbridge_driver.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/hbridge_driver.sv
// Dual H-bridge driver (L298-style) for the line-following robot.
// Synchronizes the motor controller's direction/enable/duty, generates a
// shared PWM, and runs one FSM per channel that forces a coast interval on
// every direction reversal. All bridge pins are driven from registers.
//
// Handshake: none. Commands are level-sampled every clk after a 2-flop
// synchronizer; there is no valid/ready flow control on this block.
module hbridge_driver #(
    parameter int CNT_W       = 8,
    parameter int DEAD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       motor_in,
    input  logic [1:0]       motor_en,
    input  logic [CNT_W-1:0] duty,
    output logic [3:0]       br_in,
    output logic [1:0]       br_en,
    output logic             busy,
    output logic [7:0]       rev_cnt
);

    typedef enum logic [1:0] {
        ST_COAST = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BRAKE = 2'd2,
        ST_DEAD  = 2'd3
    } ch_state_t;

    // The dead counter exits on 0, so loading N-1 gives exactly N cycles in DEAD.
    localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYCLES - 1);

    logic [3:0]       motor_m, motor_s;
    logic [1:0]       en_m, en_s;
    logic [CNT_W-1:0] duty_m, duty_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_q;
    logic             pwm;
    logic [1:0]       rev_hit;
    logic [8:0]       rev_sum;

    // Two-flop synchronizers for everything coming from the motor controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            motor_m <= '0;
            motor_s <= '0;
            en_m    <= '0;
            en_s    <= '0;
            duty_m  <= '0;
            duty_s  <= '0;
        end else begin
            motor_m <= motor_in;
            motor_s <= motor_m;
            en_m    <= motor_en;
            en_s    <= en_m;
            duty_m  <= duty;
            duty_s  <= duty_m;
        end
    end

    // Free-running PWM counter; duty is only taken at the wrap so pulses are never cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            duty_q <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == {CNT_W{1'b1}}) begin
                duty_q <= duty_s;
            end
        end
    end

    // All-ones duty means 100%, otherwise high for duty_q counts per period.
    assign pwm = (duty_q == {CNT_W{1'b1}}) || (cnt < duty_q);

    // Channel 1 is A (bits [3:2], enable [1]); channel 0 is B (bits [1:0], enable [0]).
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [1:0] cmd;
        logic       en;
        logic       is_drive;
        ch_state_t  state;
        logic [1:0] dir_q;
        logic [1:0] pend_q;
        logic [1:0] in_q;
        logic       en_q;
        logic [15:0] dcnt;
        logic       rev;
        ch_state_t  idle_state;
        logic [1:0] idle_in;
        logic       idle_en;

        assign cmd      = motor_s[2*c +: 2];
        assign en       = en_s[c];
        assign is_drive = (cmd == 2'b10) || (cmd == 2'b01);
        assign rev      = (state == ST_DRIVE) && en && is_drive && (cmd != dir_q);

        // Next state/outputs selected from a resting state (COAST, BRAKE, expired DEAD).
        always_comb begin
            idle_state = ST_COAST;
            idle_in    = 2'b00;
            idle_en    = 1'b0;
            if (en && is_drive) begin
                idle_state = ST_DRIVE;
                idle_in    = cmd;
                idle_en    = pwm;
            end else if (en && (cmd == 2'b11)) begin
                idle_state = ST_BRAKE;
                idle_in    = 2'b11;
                idle_en    = 1'b1;
            end
        end

        // Channel FSM; pin outputs are registered alongside the state they belong to.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= ST_COAST;
                dir_q  <= 2'b00;
                pend_q <= 2'b00;
                in_q   <= 2'b00;
                en_q   <= 1'b0;
                dcnt   <= '0;
            end else begin
                case (state)
                    ST_COAST, ST_BRAKE: begin
                        state <= idle_state;
                        in_q  <= idle_in;
                        en_q  <= idle_en;
                        if (idle_state == ST_DRIVE) dir_q <= cmd;
                    end
                    ST_DRIVE: begin
                        if (!en || (cmd == 2'b00)) begin
                            state <= ST_COAST;
                            in_q  <= 2'b00;
                            en_q  <= 1'b0;
                        end else if (cmd == 2'b11) begin
                            state <= ST_BRAKE;
                            in_q  <= 2'b11;
                            en_q  <= 1'b1;
                        end else if (cmd == dir_q) begin
                            in_q <= dir_q;
                            en_q <= pwm;
                        end else begin
                            state  <= ST_DEAD;
                            dcnt   <= DEAD_LOAD;
                            pend_q <= cmd;
                            in_q   <= 2'b00;
                            en_q   <= 1'b0;
                        end
                    end
                    default: begin
                        // DEAD: pins parked at coast; the latest drive request is remembered.
                        if (is_drive) pend_q <= cmd;
                        if (dcnt == 16'd0) begin
                            if (en && (cmd == pend_q)) begin
                                state <= ST_DRIVE;
                                dir_q <= pend_q;
                                in_q  <= pend_q;
                                en_q  <= pwm;
                            end else begin
                                state <= idle_state;
                                in_q  <= idle_in;
                                en_q  <= idle_en;
                                if (idle_state == ST_DRIVE) dir_q <= cmd;
                            end
                        end else begin
                            dcnt <= dcnt - 16'd1;
                            in_q <= 2'b00;
                            en_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign br_in   = {g_ch[1].in_q, g_ch[0].in_q};
    assign br_en   = {g_ch[1].en_q, g_ch[0].en_q};
    assign busy    = (g_ch[1].state == ST_DEAD) || (g_ch[0].state == ST_DEAD);
    assign rev_hit = {g_ch[1].rev, g_ch[0].rev};
    assign rev_sum = {1'b0, rev_cnt} + {8'd0, rev_hit[1]} + {8'd0, rev_hit[0]};

    // Saturating reversal counter; both channels may reverse in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rev_cnt <= '0;
        end else if (rev_sum > 9'd255) begin
            rev_cnt <= 8'd255;
        end else begin
            rev_cnt <= rev_sum[7:0];
        end
    end

endmodule
